// File: rtl/param_load_counter_pkg.sv
// Shared types for param_load_counter.
//   mode_e  : counting behaviour latched on a load (WRAP, SAT, ONESHOT, RELOAD)
//   state_e : run/done state; DONE is entered only when a ONESHOT count
//             reaches its terminal value.
package param_load_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RELOAD  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/param_load_counter.sv
// Loadable up/down counter with four terminal behaviours.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-low reset
//   load_i     : load strobe; loads count, reload value and mode
//   load_val_i : value to load (WIDTH bits)
//   mode_i     : mode, sampled only while load_i=1
//   en_i       : count enable (ignored in a load cycle)
//   up_i       : direction, 1 = up, 0 = down; sampled every cycle
//   count_o    : registered count
//   tc_o       : registered one-cycle pulse per terminal step
//   done_o     : registered ONESHOT completion flag
//   dbg_state  : registered FSM state, for observation only
//
// The terminal value follows the current up_i: all-ones when counting up,
// zero when counting down.
module param_load_counter
  import param_load_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o,
  output state_e           dbg_state
);

  logic [WIDTH-1:0] rld_q;
  mode_e            mode_q;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic             done_d;
  state_e           state_d;

  // Next-state / terminal logic for everything except the reset path.
  always_comb begin
    term    = up_i ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    count_d = count_o;
    tc_d    = 1'b0;
    done_d  = done_o;
    state_d = dbg_state;

    if (load_i) begin
      count_d = load_val_i;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (en_i && dbg_state == ST_RUN) begin
      if (count_o != term) begin
        count_d = up_i ? count_o + WIDTH'(1) : count_o - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        case (mode_q)
          // All-ones + 1 and zero - 1 wrap naturally modulo 2^WIDTH.
          MODE_WRAP:    count_d = up_i ? count_o + WIDTH'(1) : count_o - WIDTH'(1);
          MODE_SAT:     count_d = count_o;
          MODE_ONESHOT: begin
            count_d = count_o;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
          MODE_RELOAD:  count_d = rld_q;
          default:      count_d = count_o;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_o   <= '0;
      rld_q     <= '0;
      mode_q    <= MODE_WRAP;
      dbg_state <= ST_RUN;
      tc_o      <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      count_o   <= count_d;
      tc_o      <= tc_d;
      done_o    <= done_d;
      dbg_state <= state_d;
      if (load_i) begin
        rld_q  <= load_val_i;
        mode_q <= mode_e'(mode_i);
      end
    end
  end

endmodule

// File: tb/tb_param_load_counter.sv
// Directed bench for param_load_counter: a 4-bit and an 8-bit instance share
// stimulus; each vector names the instance it checks and the expected
// count/tc/done after the next rising edge.
module tb_param_load_counter;
  import param_load_counter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [1:0] mode_i = 2'b00;
  logic       en_i = 1'b0;
  logic       up_i = 1'b1;

  logic [3:0] count4;
  logic       tc4, done4;
  state_e     st4;
  logic [7:0] count8;
  logic       tc8, done8;
  state_e     st8;

  param_load_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_i(load_i), .load_val_i(load_val[3:0]),
    .mode_i(mode_i), .en_i(en_i), .up_i(up_i),
    .count_o(count4), .tc_o(tc4), .done_o(done4), .dbg_state(st4)
  );

  param_load_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load_i(load_i), .load_val_i(load_val),
    .mode_i(mode_i), .en_i(en_i), .up_i(up_i),
    .count_o(count8), .tc_o(tc8), .done_o(done8), .dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {wide, count[7:0], tc, done}
  logic [10:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- driver ----------------
  task automatic drv(input logic rst, input logic ld, input logic [7:0] lv,
                     input logic [1:0] md, input logic e, input logic u,
                     input logic wide, input logic [7:0] ec,
                     input logic etc, input logic edone);
    @(negedge clk);
    reset    = rst;
    load_i   = ld;
    load_val = lv;
    mode_i   = md;
    en_i     = e;
    up_i     = u;
    exp_q.push_back({wide, ec, etc, edone});
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [10:0] e;
    logic [7:0]  act_cnt;
    logic        act_tc, act_done;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[10]) begin
          act_cnt = count8; act_tc = tc8; act_done = done8;
        end else begin
          act_cnt = {4'h0, count4}; act_tc = tc4; act_done = done4;
        end
        n_vec++;
        if (act_cnt !== e[9:2] || act_tc !== e[1] || act_done !== e[0]) begin
          n_fail++;
          $display("FAIL vec%0d %s: got count=%0h tc=%0b done=%0b, expected count=%0h tc=%0b done=%0b",
                   n_vec, e[10] ? "w8" : "w4", act_cnt, act_tc, act_done,
                   e[9:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [1:0] WR = MODE_WRAP;
  localparam logic [1:0] SA = MODE_SAT;
  localparam logic [1:0] OS = MODE_ONESHOT;
  localparam logic [1:0] RL = MODE_RELOAD;

  // ---------------- stimulus ----------------
  initial begin
    // Reset overrides a simultaneous load and enable.
    drv(0, 1, 8'h09, SA, 1, 1, 0, 8'h0, 0, 0);
    drv(0, 0, 8'h00, WR, 0, 1, 0, 8'h0, 0, 0);
    // Out of reset: WRAP up from 0 without a load; mode_i ignored without load.
    drv(1, 0, 8'h00, SA, 1, 1, 0, 8'h1, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'h2, 0, 0);

    // WRAP up from D: D,E,F,0(tc),1. Load wins over en.
    drv(1, 1, 8'h0D, WR, 1, 1, 0, 8'hD, 0, 0);
    drv(1, 0, 8'h00, WR, 1, 1, 0, 8'hE, 0, 0);
    drv(1, 0, 8'h00, WR, 1, 1, 0, 8'hF, 0, 0);
    drv(1, 0, 8'h00, WR, 1, 1, 0, 8'h0, 1, 0);
    drv(1, 0, 8'h00, WR, 1, 1, 0, 8'h1, 0, 0);

    // SAT down from 2: 2,1,0,0(tc),0(tc); then en=0 holds with no tc.
    drv(1, 1, 8'h02, SA, 1, 0, 0, 8'h2, 0, 0);
    drv(1, 0, 8'h00, SA, 1, 0, 0, 8'h1, 0, 0);
    drv(1, 0, 8'h00, SA, 1, 0, 0, 8'h0, 0, 0);
    drv(1, 0, 8'h00, SA, 1, 0, 0, 8'h0, 1, 0);
    drv(1, 0, 8'h00, SA, 1, 0, 0, 8'h0, 1, 0);
    drv(1, 0, 8'h00, SA, 0, 0, 0, 8'h0, 0, 0);

    // ONESHOT up from C: single tc, done held while en/up toggle, load exits.
    drv(1, 1, 8'h0C, OS, 1, 1, 0, 8'hC, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hD, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hE, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hF, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hF, 1, 1);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hF, 0, 1);
    drv(1, 0, 8'h00, OS, 0, 1, 0, 8'hF, 0, 1);
    drv(1, 0, 8'h00, OS, 1, 0, 0, 8'hF, 0, 1);
    drv(1, 1, 8'h03, WR, 1, 1, 0, 8'h3, 0, 0);

    // RELOAD down from 5: 5,4,3,2,1,0,5(tc),4; then direction flips.
    drv(1, 1, 8'h05, RL, 1, 0, 0, 8'h5, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h4, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h3, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h2, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h1, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h0, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h5, 1, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h4, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 1, 0, 8'h5, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 0, 0, 8'h4, 0, 0);

    // RELOAD with reload value equal to TERM: stays at F, tc every step.
    drv(1, 1, 8'h0F, RL, 1, 1, 0, 8'hF, 0, 0);
    drv(1, 0, 8'h00, RL, 1, 1, 0, 8'hF, 1, 0);
    drv(1, 0, 8'h00, RL, 1, 1, 0, 8'hF, 1, 0);
    drv(1, 0, 8'h00, RL, 0, 1, 0, 8'hF, 0, 0);

    // Load and enable together at 7 -> 9.
    drv(1, 1, 8'h07, WR, 0, 1, 0, 8'h7, 0, 0);
    drv(1, 1, 8'h09, WR, 1, 1, 0, 8'h9, 0, 0);

    // Reset while in ONESHOT DONE, then WRAP counting from 0.
    drv(1, 1, 8'h0E, OS, 1, 1, 0, 8'hE, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hF, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hF, 1, 1);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'hF, 0, 1);
    drv(0, 0, 8'h00, OS, 1, 1, 0, 8'h0, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'h1, 0, 0);
    drv(1, 0, 8'h00, OS, 1, 1, 0, 8'h2, 0, 0);

    // 8-bit instance: WRAP up FE,FF,00(tc); down from 00 -> FF(tc), FE.
    drv(1, 1, 8'hFE, WR, 1, 1, 1, 8'hFE, 0, 0);
    drv(1, 0, 8'h00, WR, 1, 1, 1, 8'hFF, 0, 0);
    drv(1, 0, 8'h00, WR, 1, 1, 1, 8'h00, 1, 0);
    drv(1, 0, 8'h00, WR, 1, 0, 1, 8'hFF, 1, 0);
    drv(1, 0, 8'h00, WR, 1, 0, 1, 8'hFE, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/param_load_counter.md
PARAM_LOAD_COUNTER -- requirements
Module: param_load_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock; every flop updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 Port: load_i  input  1  load strobe.
REQ-005 Port: load_val_i  input  WIDTH  value loaded into the count and reload registers.
REQ-006 Port: mode_i  input  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 RELOAD; sampled only when load_i=1.
REQ-007 Port: en_i  input  1  count enable.
REQ-008 Port: up_i  input  1  direction (1 up, 0 down); sampled every cycle.
REQ-009 Port: count_o  output  WIDTH  registered count.
REQ-010 Port: tc_o  output  1  registered terminal-count pulse.
REQ-011 Port: done_o  output  1  registered ONESHOT completion flag.

Function
REQ-012 Internal registers: count, reload value rld_q, mode_q, FSM state {RUN, DONE}, tc_o, done_o.
REQ-013 Terminal value TERM is all-ones when up_i=1 and zero when up_i=0; it is evaluated in the current cycle.
REQ-014 load_i=1 sets count<=load_val_i, rld_q<=load_val_i, mode_q<=mode_i, state<=RUN, done_o<=0 and tc_o<=0 on the next edge, in any state.
REQ-015 load_i has priority over en_i; en_i is ignored in a load cycle.
REQ-016 Step: load_i=0, en_i=1 and state=RUN; with no step, count holds.
REQ-017 Step with count!=TERM: count advances by +1 (up) or -1 (down), modulo 2^WIDTH; tc_o<=0.
REQ-018 Step with count==TERM under WRAP: count wraps (all-ones->0 up, 0->all-ones down); tc_o<=1.
REQ-019 Step with count==TERM under SAT: count holds at TERM; tc_o<=1 on every such step.
REQ-020 Step with count==TERM under ONESHOT: count holds, state<=DONE, done_o<=1, tc_o<=1 for that step only.
REQ-021 Step with count==TERM under RELOAD: count<=rld_q, tc_o<=1.
REQ-022 In DONE, en_i and up_i have no effect: count, done_o=1 and state hold, tc_o=0; only load_i or reset exits DONE.
REQ-023 tc_o is high for exactly one cycle per terminal step, and is 0 in any cycle without a terminal step.
REQ-024 A direction change mid-count takes effect immediately; TERM follows the current up_i.
REQ-025 mode_i changes while load_i=0 have no effect.
REQ-026 RELOAD with rld_q==TERM: count stays at TERM and tc_o is high on every step.

Reset
REQ-027 reset=0 at a rising edge forces count=0, rld_q=0, mode_q=WRAP, state=RUN, tc_o=0, done_o=0; it overrides load_i and en_i.
REQ-028 After reset is released, counting proceeds in WRAP mode from 0 without a load.
REQ-029 Reset asserted mid-operation, including in DONE, aborts the operation with no tc_o pulse.

Structure
REQ-030 A shared package holds the mode encoding (typedef: MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RELOAD) and the FSM state typedef {ST_RUN, ST_DONE}.
REQ-031 The block is a single module with no sub-modules; the next-count/terminal logic is one combinational block feeding the registers.
REQ-032 No latches; all outputs are driven directly from flops.

Verification
REQ-033 WIDTH=4, WRAP, up, load 0xD, en=1 -> count D,E,F,0,1; tc_o=1 only in the cycle after F->0.
REQ-034 SAT, down, load 0x2, en=1 for 5 cycles -> 2,1,0,0,0; tc_o high on each step taken at 0; done_o=0.
REQ-035 ONESHOT, up, load 0xC, en=1 -> C,D,E,F,F...; single tc_o pulse; done_o=1 held while en toggles; load 0x3 -> done_o=0, count 3.
REQ-036 RELOAD, down, load 0x5, en=1 -> 5,4,3,2,1,0,5,4; tc_o pulse after each 0->5.
REQ-037 load_i and en_i both high at count=7 with load_val_i=0x9 -> count 9; reset=0 while in ONESHOT DONE -> count 0, done_o 0, tc_o 0, then WRAP counting.
REQ-038 WIDTH=8, WRAP, up, load 0xFE -> FE,FF,00 with a tc_o pulse; down from 0x00 -> FF with a tc_o pulse.
